// File: rtl/gate_sweep_checker_if.sv
// Operand/result bundle between the gate sweep checker (master) and the gate
// library under test plus its controller (slave).
interface gate_sweep_checker_if #(
  parameter int WIDTH = 1
);
  logic             start;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] and_in;
  logic [WIDTH-1:0] or_in;
  logic [WIDTH-1:0] nand_in;
  logic [WIDTH-1:0] nor_in;
  logic [WIDTH-1:0] not_in;
  logic [WIDTH-1:0] xor_in;
  logic [WIDTH-1:0] xnor_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic [6:0]       first_err_vec;
  logic [WIDTH-1:0] first_err_a;
  logic [WIDTH-1:0] first_err_b;

  modport master (
    input  start, and_in, or_in, nand_in, nor_in, not_in, xor_in, xnor_in,
    output a_out, b_out, busy, done, pass, err_count,
           first_err_vec, first_err_a, first_err_b
  );

  modport slave (
    output start, and_in, or_in, nand_in, nor_in, not_in, xor_in, xnor_in,
    input  a_out, b_out, busy, done, pass, err_count,
           first_err_vec, first_err_a, first_err_b
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Sweeps every (A,B) operand pair through the basic gates and checks all seven
// results. Optional macro GATE_CHK_STOP_ON_ERR_EN: stop and freeze on first failure.
module gate_sweep_checker #(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst,
  gate_sweep_checker_if.master bus
);
  localparam int VW = 2 * WIDTH;
  localparam logic [VW-1:0] VEC_ONE  = VW'(1);
  localparam logic [7:0]    SET_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           r_state;
  logic [VW-1:0]    r_vec;
  logic [7:0]       r_cnt;
  logic             r_busy, r_done, r_pass;
  logic [15:0]      r_err;
  logic [6:0]       r_fvec;
  logic [WIDTH-1:0] r_fa, r_fb;

  logic [WIDTH-1:0]      w_a, w_b;
  logic [6:0][WIDTH-1:0] w_got, w_exp;
  logic [6:0]            w_flag;
  logic                  w_fail, w_last;

  assign w_a = r_vec[WIDTH-1:0];
  assign w_b = r_vec[VW-1:WIDTH];

  // Index g of both arrays is flag bit g: and, or, nand, nor, not, xor, xnor.
  assign w_got = {bus.xnor_in, bus.xor_in, bus.not_in, bus.nor_in,
                  bus.nand_in, bus.or_in, bus.and_in};
  assign w_exp = {~(w_a ^ w_b), w_a ^ w_b, ~w_a, ~(w_a | w_b),
                  ~(w_a & w_b), w_a | w_b, w_a & w_b};

  always_comb begin
    w_flag = '0;
    for (int g = 0; g < 7; g++) w_flag[g] = |(w_got[g] ^ w_exp[g]);
  end

  assign w_fail = |w_flag;
  assign w_last = &r_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fvec  <= '0;
      r_fa    <= '0;
      r_fb    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_vec   <= '0;
          r_cnt   <= '0;
          r_err   <= '0;
          r_fvec  <= '0;
          r_fa    <= '0;
          r_fb    <= '0;
          r_pass  <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= SETTLE;
        end
        SETTLE: begin
          if (r_cnt == SET_LAST) begin
            r_cnt   <= '0;
            r_state <= CHECK;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        CHECK: begin
          if (w_fail) begin
            if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            // err_count is still zero only while no vector has failed yet
            if (r_err == 16'd0) begin
              r_fvec <= w_flag;
              r_fa   <= w_a;
              r_fb   <= w_b;
            end
          end
`ifdef GATE_CHK_STOP_ON_ERR_EN
          if (w_fail || w_last) begin
`else
          if (w_last) begin
`endif
            r_state <= DONE;
          end else begin
            r_vec   <= r_vec + VEC_ONE;
            r_state <= SETTLE;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_pass  <= (r_err == 16'd0);
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.a_out         = w_a;
  assign bus.b_out         = w_b;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.pass          = r_pass;
  assign bus.err_count     = r_err;
  assign bus.first_err_vec = r_fvec;
  assign bus.first_err_a   = r_fa;
  assign bus.first_err_b   = r_fb;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (W=1/S=1 and W=2/S=3) fed by a
// fault-injectable gate model, checked each cycle against a sweep-level model.
module tb_gate_sweep_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  logic       start_r[2];
  int         fault_r[2];
  logic       done_o[2], busy_o[2], pass_o[2];
  logic [15:0] err_o[2];
  logic [6:0] fv_o[2];
  logic [1:0] a_o[2], b_o[2], fa_o[2], fb_o[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Gate library stand-in; fault 1: and stuck 0, 2: xor stuck 0, 3: nor inverted.
  function automatic logic [6:0][1:0] gates(input int f, input logic [1:0] a, input logic [1:0] b);
    logic [6:0][1:0] r;
    r[0] = a & b;    r[1] = a | b;  r[2] = ~(a & b); r[3] = ~(a | b);
    r[4] = ~a;       r[5] = a ^ b;  r[6] = ~(a ^ b);
    if (f == 1) r[0] = '0;
    if (f == 2) r[5] = '0;
    if (f == 3) r[3] = ~r[3];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int W = (g == 0) ? 1 : 2;
    localparam int S = (g == 0) ? 1 : 3;
    localparam int N = 1 << (2 * W);

    gate_sweep_checker_if #(.WIDTH(W)) bus ();
    gate_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .bus(bus.master)
    );

    logic [6:0][1:0] res;
    assign res = gates(fault_r[g], 2'(bus.a_out), 2'(bus.b_out));
    assign bus.start   = start_r[g];
    assign bus.and_in  = res[0][W-1:0];
    assign bus.or_in   = res[1][W-1:0];
    assign bus.nand_in = res[2][W-1:0];
    assign bus.nor_in  = res[3][W-1:0];
    assign bus.not_in  = res[4][W-1:0];
    assign bus.xor_in  = res[5][W-1:0];
    assign bus.xnor_in = res[6][W-1:0];
    assign done_o[g] = bus.done;
    assign busy_o[g] = bus.busy;
    assign pass_o[g] = bus.pass;
    assign err_o[g]  = bus.err_count;
    assign fv_o[g]   = bus.first_err_vec;
    assign a_o[g]    = 2'(bus.a_out);
    assign b_o[g]    = 2'(bus.b_out);
    assign fa_o[g]   = 2'(bus.first_err_a);
    assign fb_o[g]   = 2'(bus.first_err_b);

    // Sweep model: k = edges since the accepting edge; each vector owns S+1 edges.
    bit         act = 0;
    int         k = 0, m_end = 0, last = 0, fi = -1;
    bit [6:0]   flags_v[16];
    logic       e_busy = 0, e_done = 0, e_pass = 0;
    logic [15:0] e_err = 0;
    logic [6:0] e_fv = 0;
    logic [1:0] e_a = 0, e_b = 0, e_fa = 0, e_fb = 0;

    task automatic prepare();
      logic [6:0][1:0] id, fl;
      fi = -1;
      for (int v = 0; v < N; v++) begin
        id = gates(0, 2'(v % (1 << W)), 2'(v >> W));
        fl = gates(fault_r[g], 2'(v % (1 << W)), 2'(v >> W));
        for (int gt = 0; gt < 7; gt++) flags_v[v][gt] = (id[gt][W-1:0] != fl[gt][W-1:0]);
        if (fi < 0 && flags_v[v] != 0) fi = v;
      end
      last = N - 1;
`ifdef GATE_CHK_STOP_ON_ERR_EN
      if (fi >= 0) last = fi;
`endif
      m_end = (last + 1) * (S + 1);
    endtask

    task automatic eval();
      int c, vec, n;
      c   = k / (S + 1);
      vec = (c > last) ? last : c;
      n   = 0;
      for (int v = 0; v < c; v++) if (flags_v[v] != 0) n++;
      e_busy = 1; e_pass = 0;
      e_a = 2'(vec % (1 << W));
      e_b = 2'(vec >> W);
      e_err = 16'(n);
      if (fi >= 0 && fi < c) begin
        e_fv = flags_v[fi]; e_fa = 2'(fi % (1 << W)); e_fb = 2'(fi >> W);
      end else begin
        e_fv = 0; e_fa = 0; e_fb = 0;
      end
    endtask

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        act = 0; e_busy = 0; e_done = 0; e_pass = 0; e_err = 0;
        e_fv = 0; e_a = 0; e_b = 0; e_fa = 0; e_fb = 0;
      end else begin
        e_done = 0;
        if (!act) begin
          if (start_r[g]) begin
            prepare(); act = 1; k = 0; eval();
          end
        end else begin
          k++;
          if (k == m_end + 1) begin
            act = 0; e_done = 1; e_busy = 0; e_pass = (e_err == 0);
          end else begin
            eval();
          end
        end
      end
    end

    always @(negedge clk) begin
      if (!rst)
        chk($sformatf("u%0d cycle outputs", g),
            64'({bus.busy, bus.done, bus.pass, bus.err_count, bus.first_err_vec,
                 2'(bus.a_out), 2'(bus.b_out), 2'(bus.first_err_a), 2'(bus.first_err_b)}),
            64'({e_busy, e_done, e_pass, e_err, e_fv, e_a, e_b, e_fa, e_fb}));
    end
  end

  // Waits for done on instance g; returns edges since the accepting edge t0, -1 on timeout.
  task automatic wait_done(input int g, input int t0, output int d);
    d = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done_o[g]) begin
        d = edge_n - t0;
        break;
      end
    end
  endtask

  task automatic run(input int g, input int f, output int d);
    int t0;
    fault_r[g] = f;
    @(negedge clk);
    start_r[g] = 1'b1;
    t0 = edge_n + 1;
    @(negedge clk);
    start_r[g] = 1'b0;
    wait_done(g, t0, d);
  endtask

  initial begin
    int d, t0, seen;
    start_r[0] = 0; start_r[1] = 0;
    fault_r[0] = 0; fault_r[1] = 0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++)
      chk($sformatf("u%0d reset outputs", g),
          64'({busy_o[g], done_o[g], pass_o[g], err_o[g], fv_o[g], a_o[g], b_o[g], fa_o[g], fb_o[g]}), 64'd0);
    rst = 1'b0;

    run(0, 0, d);
    chk("ideal done edge", 64'(d), 64'd9);
    chk("ideal pass", 64'(pass_o[0]), 64'd1);
    chk("ideal err_count", 64'(err_o[0]), 64'd0);
    chk("operands held", 64'({a_o[0], b_o[0]}), 64'h5);

    run(0, 1, d);
    chk("and0 done edge", 64'(d), 64'd9);
    chk("and0 pass", 64'(pass_o[0]), 64'd0);
    chk("and0 err_count", 64'(err_o[0]), 64'd1);
    chk("and0 first vec", 64'(fv_o[0]), 64'h01);
    chk("and0 first a/b", 64'({fa_o[0], fb_o[0]}), 64'h5);

    run(1, 2, d);
`ifdef GATE_CHK_STOP_ON_ERR_EN
    chk("xor0 done edge", 64'(d), 64'd9);
    chk("xor0 err_count", 64'(err_o[1]), 64'd1);
`else
    chk("xor0 done edge", 64'(d), 64'd65);
    chk("xor0 err_count", 64'(err_o[1]), 64'd12);
`endif
    chk("xor0 first vec", 64'(fv_o[1]), 64'h20);
    chk("xor0 first a/b", 64'({fa_o[1], fb_o[1]}), 64'h4);

    // Reset while vector 2 is on the operand bus.
    fault_r[0] = 0;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("mid-sweep reset outputs",
           64'({busy_o[0], done_o[0], pass_o[0], err_o[0], fv_o[0], a_o[0], b_o[0], fa_o[0], fb_o[0]}), 64'd0);
    seen = 0;
    repeat (2) @(negedge clk) if (done_o[0]) seen++;
    rst = 1'b0;
    repeat (12) @(negedge clk) if (done_o[0]) seen++;
    chk("no done after reset", 64'(seen), 64'd0);
    run(0, 0, d);
    chk("fresh sweep done edge", 64'(d), 64'd9);
    chk("fresh sweep pass", 64'(pass_o[0]), 64'd1);

    // Second start pulse sampled at edge 3 of a running sweep.
    @(negedge clk);
    start_r[0] = 1'b1;
    t0 = edge_n + 1;
    @(negedge clk);
    start_r[0] = 1'b0;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    wait_done(0, t0, d);
    chk("restart ignored done edge", 64'(d), 64'd9);

    // Start held high: back-to-back sweeps.
    @(negedge clk);
    start_r[0] = 1'b1;
    t0 = edge_n + 1;
    wait_done(0, t0, d);
    chk("b2b first done edge", 64'(d), 64'd9);
    wait_done(0, t0, d);
    chk("b2b second done edge", 64'(d), 64'd19);
    start_r[0] = 1'b0;

    run(0, 3, d);
`ifdef GATE_CHK_STOP_ON_ERR_EN
    chk("nor inv done edge", 64'(d), 64'd3);
    chk("nor inv err_count", 64'(err_o[0]), 64'd1);
`else
    chk("nor inv done edge", 64'(d), 64'd9);
    chk("nor inv err_count", 64'(err_o[0]), 64'd4);
`endif
    chk("nor inv first vec", 64'(fv_o[0]), 64'h08);
    chk("nor inv first a/b", 64'({fa_o[0], fb_o[0]}), 64'h0);
    repeat (3) @(negedge clk);
`ifdef GATE_CHK_STOP_ON_ERR_EN
    chk("nor inv operands frozen", 64'({a_o[0], b_o[0]}), 64'h0);
`else
    chk("nor inv operands held", 64'({a_o[0], b_o[0]}), 64'h5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
